wb_cmd_executor: RTL and testbench
==================================

WB_CMD_EXECUTOR -- requirements
Module: wb_cmd_executor

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: the maximum number of cycles to wait for ack/err before aborting.
REQ-002 The block SHALL have parameter ADDR_W, default 30: the Wishbone word-address width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 i_cmd_stb  in  1  command strobe from the command generator; may stay high for 1 or more cycles per command.
REQ-006 i_cmd_word  in  34  [33:32]=opcode, [31:0]=payload.
REQ-007 o_busy  out  1  high from command acceptance until the response strobe.
REQ-008 o_overrun  out  1  sticky flag: a command edge arrived while busy.
REQ-009 o_rsp_stb  out  1  one-cycle response-valid pulse.
REQ-010 o_rsp_word  out  34  response, same framing as i_cmd_word.
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone B4 pipelined master controls.
REQ-012 o_wb_addr  out  ADDR_W  word address.
REQ-013 o_wb_data  out  32  write data.
REQ-014 o_wb_sel  out  4  byte selects; constant 4'hF.
REQ-015 i_wb_stall, i_wb_ack, i_wb_err  in  1 each  slave responses.
REQ-016 i_wb_data  in  32  read data.

Function
REQ-017 The block SHALL accept a command only on the rising edge of i_cmd_stb (i_cmd_stb=1 with a registered previous value of 0), capturing i_cmd_word in that cycle; a strobe held high SHALL be treated as one command.
REQ-018 A rising edge while o_busy=1 SHALL be dropped and SHALL set o_overrun; o_overrun SHALL clear only on reset.
REQ-019 Opcodes: 2'b10 SET_ADDR, 2'b00 READ, 2'b01 WRITE, 2'b11 ABORT.
REQ-020 SET_ADDR SHALL load addr_reg=payload[ADDR_W-1:0] and inc_en=payload[30], issue no bus cycle, and respond {2'b10, payload} one cycle after acceptance.
REQ-021 READ and WRITE SHALL use the FSM IDLE -> REQ -> WAIT_ACK -> RESP -> IDLE.
REQ-022 REQ: cyc=1, stb=1, we=(opcode==WRITE), addr=addr_reg, data=payload; the FSM SHALL remain in REQ while i_wb_stall=1.
REQ-023 When REQ sees stall=0 and ack/err=0 it SHALL go to WAIT_ACK with stb=0 and cyc=1; an ack/err arriving in the same cycle as stall=0 SHALL go directly to RESP.
REQ-024 WAIT_ACK SHALL go to RESP on i_wb_ack or i_wb_err; ack and err together SHALL be treated as err.
REQ-025 The timeout counter SHALL start at acceptance, count every cycle in REQ and WAIT_ACK, and force RESP with a timeout status once it reaches TIMEOUT_CYCLES.
REQ-026 In RESP, cyc and stb SHALL be 0 and o_rsp_stb=1 for exactly one cycle; the FSM SHALL return to IDLE on the next cycle.
REQ-027 Read-OK response SHALL be {2'b00, i_wb_data latched at ack}.
REQ-028 Write-OK response SHALL be {2'b01, 32'h0}.
REQ-029 Bus-error response SHALL be {2'b11, 32'h0000_0001}.
REQ-030 Timeout response SHALL be {2'b11, 32'h0000_0002}.
REQ-031 On a successful ack with inc_en=1, addr_reg SHALL increment by 1, wrapping modulo 2^ADDR_W; on err or timeout it SHALL NOT increment.
REQ-032 ABORT SHALL be accepted in any state, even while busy, without setting o_overrun; it SHALL drop cyc/stb in the next cycle, return the FSM to IDLE, and respond {2'b11, 32'h0000_0003}; any response pending in the same cycle SHALL be discarded.
REQ-033 Exactly one o_rsp_stb SHALL be produced per accepted command.
REQ-034 o_rsp_word SHALL hold its value until the next response.

Reset
REQ-035 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, except o_wb_sel=4'hF.
REQ-036 Reset SHALL clear addr_reg, inc_en, the timeout counter, o_overrun, and the strobe-edge register.
REQ-037 Reset asserted mid-transaction SHALL drop cyc in the next cycle and produce no response.

Structure
REQ-038 A shared package SHALL hold the opcode constants, the response status codes (1/2/3), the FSM state encoding, and the 34-bit word width.
REQ-039 No sub-module is required; the edge detector stays inline.

Verification
REQ-040 SET_ADDR 0x40000001, stb held 2 cycles -> one response 0x2_4000_0001, addr_reg=1, inc_en=1, no cyc.
REQ-041 WRITE 0x1_DEADBEEF, stall 3 cycles, ack 2 cycles later -> wb addr=1, we=1, data 0xDEADBEEF; response 0x1_0000_0000; addr_reg becomes 2.
REQ-042 READ, slave ack with 0x12345678 -> response 0x0_1234_5678.
REQ-043 READ with no ack, TIMEOUT_CYCLES=15 -> cyc drops at cycle 15; response 0x3_0000_0002; addr_reg unchanged.
REQ-044 Second command edge while busy -> o_overrun=1, single response; ABORT during WAIT_ACK -> response 0x3_0000_0003, cyc=0.
REQ-045 rst_n low during REQ -> cyc=0 next cycle, no o_rsp_stb, all registers cleared.

Source files
------------

// File: rtl/wb_cmd_executor_pkg.sv
// Shared constants for the Wishbone command executor: word framing, opcodes,
// response status codes and the bus FSM encoding.
package wb_cmd_executor_pkg;

  localparam int WORD_W = 34;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_SET_ADDR = 2'b10;
  localparam logic [1:0] OP_ABORT    = 2'b11;

  localparam logic [31:0] ST_BUS_ERR = 32'h0000_0001;
  localparam logic [31:0] ST_TIMEOUT = 32'h0000_0002;
  localparam logic [31:0] ST_ABORT   = 32'h0000_0003;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  // Status responses share the ABORT opcode slot as their framing.
  function automatic logic [WORD_W-1:0] status_word(input logic [31:0] code);
    return {OP_ABORT, code};
  endfunction

endpackage

// File: rtl/wb_cmd_executor.sv
// Executes edge-strobed 34-bit commands as single Wishbone B4 pipelined
// transfers, with a per-transfer timeout and an abort that works in any state.
module wb_cmd_executor
  import wb_cmd_executor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_W         = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_stb,
  input  logic [WORD_W-1:0] i_cmd_word,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_rsp_stb,
  output logic [WORD_W-1:0] o_rsp_word,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [31:0]       i_wb_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_next;
  logic              stb_q;
  logic              busy_q;
  logic              overrun_q;
  logic              inc_en;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_q;
  logic              we_q;
  logic [CNT_W-1:0]  tcnt;
  logic              rsp_stb_q;
  logic [WORD_W-1:0] rsp_word_q;

  logic [1:0]  op;
  logic [31:0] payload;
  logic        cmd_edge, is_abort, abort_hit, accept, bus_accept, set_accept;
  logic        in_bus, got_ack, got_err, timed_out;

  assign op         = i_cmd_word[33:32];
  assign payload    = i_cmd_word[31:0];
  assign cmd_edge   = i_cmd_stb & ~stb_q;
  assign is_abort   = (op == OP_ABORT);
  assign abort_hit  = cmd_edge & is_abort;
  assign accept     = cmd_edge & ~busy_q & ~is_abort;
  assign bus_accept = accept & ((op == OP_READ) || (op == OP_WRITE));
  assign set_accept = accept & (op == OP_SET_ADDR);
  assign in_bus     = (state == S_REQ) || (state == S_WAIT_ACK);

  always_comb begin
    state_next = state;
    got_ack    = 1'b0;
    got_err    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: if (bus_accept) state_next = S_REQ;
      S_REQ, S_WAIT_ACK: begin
        // A response only counts once the request has left REQ unstalled.
        if ((state == S_WAIT_ACK) || !i_wb_stall) begin
          got_err = i_wb_err;
          got_ack = i_wb_ack & ~i_wb_err;
        end
        if (got_ack || got_err) begin
          state_next = S_RESP;
        end else if (tcnt >= CNT_LAST) begin
          timed_out  = 1'b1;
          state_next = S_RESP;
        end else if ((state == S_REQ) && !i_wb_stall) begin
          state_next = S_WAIT_ACK;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort_hit) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      inc_en     <= 1'b0;
      addr_reg   <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      tcnt       <= '0;
      rsp_stb_q  <= 1'b0;
      rsp_word_q <= '0;
    end else begin
      state     <= state_next;
      stb_q     <= i_cmd_stb;
      rsp_stb_q <= 1'b0;

      if (cmd_edge && busy_q && !is_abort) overrun_q <= 1'b1;

      // Busy spans acceptance through the cycle the response strobe is shown.
      if (accept || abort_hit) busy_q <= 1'b1;
      else if (rsp_stb_q)      busy_q <= 1'b0;

      if (bus_accept) begin
        data_q <= payload;
        we_q   <= (op == OP_WRITE);
        tcnt   <= CNT_W'(1);
      end else if (in_bus) begin
        tcnt <= tcnt + CNT_W'(1);
      end

      // Abort wins over any completion landing in the same cycle.
      if (abort_hit) begin
        rsp_stb_q  <= 1'b1;
        rsp_word_q <= status_word(ST_ABORT);
      end else if (set_accept) begin
        addr_reg   <= payload[ADDR_W-1:0];
        inc_en     <= payload[30];
        rsp_stb_q  <= 1'b1;
        rsp_word_q <= {OP_SET_ADDR, payload};
      end else if (got_ack) begin
        rsp_stb_q  <= 1'b1;
        rsp_word_q <= we_q ? {OP_WRITE, 32'h0} : {OP_READ, i_wb_data};
        if (inc_en) addr_reg <= addr_reg + ADDR_W'(1);
      end else if (got_err) begin
        rsp_stb_q  <= 1'b1;
        rsp_word_q <= status_word(ST_BUS_ERR);
      end else if (timed_out) begin
        rsp_stb_q  <= 1'b1;
        rsp_word_q <= status_word(ST_TIMEOUT);
      end
    end
  end

  assign o_busy     = busy_q;
  assign o_overrun  = overrun_q;
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_word = rsp_word_q;
  assign o_wb_cyc   = in_bus;
  assign o_wb_stb   = (state == S_REQ);
  assign o_wb_we    = in_bus & we_q;
  assign o_wb_addr  = addr_reg;
  assign o_wb_data  = data_q;
  assign o_wb_sel   = 4'hF;

endmodule

// File: tb/tb_wb_cmd_executor.sv
// Directed bench for wb_cmd_executor with hand-computed expected values.
module tb_wb_cmd_executor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        busy, overrun, rsp_stb;
  logic [33:0] rsp_word;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        stall, ack, err;
  logic [31:0] wb_rdata;

  int total = 0;
  int bad   = 0;
  int rsp_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  wb_cmd_executor #(.TIMEOUT_CYCLES(15), .ADDR_W(30)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cmd_stb  (cmd_stb),
    .i_cmd_word (cmd_word),
    .o_busy     (busy),
    .o_overrun  (overrun),
    .o_rsp_stb  (rsp_stb),
    .o_rsp_word (rsp_word),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_wdata),
    .o_wb_sel   (wb_sel),
    .i_wb_stall (stall),
    .i_wb_ack   (ack),
    .i_wb_err   (err),
    .i_wb_data  (wb_rdata)
  );

  always @(posedge clk) if (rsp_stb) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [33:0] w);
    cmd_stb  = 1'b1;
    cmd_word = w;
    tick();
    cmd_stb  = 1'b0;
  endtask

  initial begin
    int hi;
    rst_n = 1'b0; cmd_stb = 1'b0; cmd_word = '0;
    stall = 1'b0; ack = 1'b0; err = 1'b0; wb_rdata = '0;
    repeat (3) tick();
    chk("rst_ctrl", {busy, overrun, rsp_stb, wb_cyc, wb_stb, wb_we}, 6'b0);
    chk("rst_rsp_word", rsp_word, 34'h0);
    chk("rst_addr_data", {wb_addr, wb_wdata}, 62'h0);
    chk("rst_sel", wb_sel, 4'hF);
    rst_n = 1'b1;
    tick();

    // SET_ADDR with strobe held for two cycles
    cmd_stb = 1'b1; cmd_word = {2'b10, 32'h4000_0001};
    tick();
    chk("set_rsp_stb", rsp_stb, 1'b1);
    chk("set_rsp_word", rsp_word, 34'h2_4000_0001);
    chk("set_no_cyc", wb_cyc, 1'b0);
    tick();
    cmd_stb = 1'b0;
    chk("set_rsp_once", rsp_stb, 1'b0);
    chk("set_addr", wb_addr, 30'd1);
    tick(); tick();
    chk("set_rsp_cnt", rsp_cnt, 1);
    chk("set_idle_busy", busy, 1'b0);

    // WRITE with 3 stalled cycles, ack 2 cycles after the request is taken
    stall = 1'b1;
    issue({2'b01, 32'hDEAD_BEEF});
    chk("wr_req", {wb_cyc, wb_stb, wb_we, busy}, 4'b1111);
    chk("wr_addr", wb_addr, 30'd1);
    chk("wr_data", wb_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      chk("wr_stalled_stb", wb_stb, 1'b1);
      tick();
    end
    chk("wr_still_req", wb_stb, 1'b1);
    stall = 1'b0;
    tick();
    chk("wr_wait", {wb_cyc, wb_stb}, 2'b10);
    tick();
    chk("wr_wait2", {wb_cyc, rsp_stb}, 2'b10);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("wr_rsp", {rsp_stb, wb_cyc, wb_stb}, 3'b100);
    chk("wr_rsp_word", rsp_word, 34'h1_0000_0000);
    tick();
    chk("wr_addr_inc", wb_addr, 30'd2);
    chk("wr_rsp_hold", {rsp_stb, rsp_word}, {1'b0, 34'h1_0000_0000});
    chk("wr_busy_clr", busy, 1'b0);

    // READ: ack in the same cycle the request leaves unstalled
    issue({2'b00, 32'h0});
    chk("rd_req", {wb_cyc, wb_stb, wb_we}, 3'b110);
    chk("rd_addr", wb_addr, 30'd2);
    ack = 1'b1; wb_rdata = 32'h1234_5678;
    tick();
    ack = 1'b0; wb_rdata = 32'h0;
    chk("rd_rsp", {rsp_stb, wb_cyc}, 2'b10);
    chk("rd_rsp_word", rsp_word, 34'h0_1234_5678);
    tick();
    chk("rd_addr_inc", wb_addr, 30'd3);
    chk("rd_rsp_hold", rsp_word, 34'h0_1234_5678);

    // ack and err together is a bus error; no increment
    issue({2'b00, 32'h0});
    tick();
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    chk("err_rsp", rsp_stb, 1'b1);
    chk("err_rsp_word", rsp_word, 34'h3_0000_0001);
    tick();
    chk("err_no_inc", wb_addr, 30'd3);

    // READ with no ack times out: cyc high in cycles 1..14 after acceptance
    snap = rsp_cnt;
    issue({2'b00, 32'h0});
    hi = 0;
    for (int c = 1; c <= 14; c++) begin
      if (wb_cyc && !rsp_stb) hi++;
      tick();
    end
    chk("to_cyc_cycles", hi, 14);
    chk("to_cyc_drop", {wb_cyc, rsp_stb}, 2'b01);
    chk("to_rsp_word", rsp_word, 34'h3_0000_0002);
    tick();
    chk("to_addr_kept", wb_addr, 30'd3);
    chk("to_one_rsp", rsp_cnt - snap, 1);

    // Address wrap modulo 2^30
    issue({2'b10, 32'h7FFF_FFFF});
    chk("wrap_set_word", rsp_word, 34'h2_7FFF_FFFF);
    tick();
    issue({2'b01, 32'h0000_0055});
    chk("wrap_addr_top", wb_addr, 30'h3FFF_FFFF);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("wrap_addr_zero", wb_addr, 30'h0);

    // Overrun on second edge while busy, then ABORT during WAIT_ACK
    chk("ovr_clear_before", overrun, 1'b0);
    snap = rsp_cnt;
    stall = 1'b1;
    issue({2'b00, 32'h0});
    tick();
    issue({2'b01, 32'h1111_1111});
    chk("ovr_set", {overrun, busy}, 2'b11);
    stall = 1'b0;
    tick();
    chk("ovr_first_cmd", {wb_cyc, wb_stb, wb_we}, 3'b100);
    issue({2'b11, 32'h0});
    chk("abort_cyc", {wb_cyc, wb_stb}, 2'b00);
    chk("abort_rsp", rsp_stb, 1'b1);
    chk("abort_rsp_word", rsp_word, 34'h3_0000_0003);
    tick();
    chk("abort_one_rsp", rsp_cnt - snap, 1);
    chk("ovr_sticky", {overrun, busy}, 2'b10);

    // Reset during REQ
    issue({2'b10, 32'h0000_0005});
    tick();
    snap = rsp_cnt;
    stall = 1'b1;
    issue({2'b00, 32'h0});
    chk("mrst_req", {wb_cyc, wb_addr}, {1'b1, 30'd5});
    rst_n = 1'b0;
    tick();
    chk("mrst_cyc", {wb_cyc, wb_stb, rsp_stb, busy, overrun}, 5'b0);
    chk("mrst_regs", {wb_addr, wb_wdata, rsp_word}, 96'h0);
    rst_n = 1'b1; stall = 1'b0;
    tick(); tick(); tick();
    chk("mrst_no_rsp", rsp_cnt - snap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
